alu_seq: RTL

- Parametrised, handshaked successor to the team's 32-bit combinational ALU.
- Keeps the 4-bit opcode map.
- Generalises data width.
- Replaces the fixed %3, /4, >>2 and <<2 with true operand-driven modulo, divide and shifts. Divide and modulo run on an iterative restoring divider.
- Registers the result with status flags behind a valid/ready output.
- Sits between the instruction decode/issue stage and writeback.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Handshake bundle between the issue stage and the sequential ALU.
// The issue side (master) presents operands and opcode and consumes the
// registered result; the ALU (slave) accepts operations and produces results.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             dz;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, c, zero, carry, ovf, dz
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, c, zero, carry, ovf, dz
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake on both sides.
// Single-cycle opcodes complete in one cycle; divide and modulo with a
// non-zero divisor run on an iterative restoring divider producing one
// quotient bit per cycle, MSB first. The result and its status flags are
// registered and held until the consumer accepts them.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reduction parity used by opcodes 14 and 15.
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  state_t           state_r;
  state_t           state_s;

  logic             accept_s;
  logic             b_zero_s;
  logic             div_start_s;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_c_s;
  logic             alu_carry_s;
  logic             alu_ovf_s;
  logic             alu_dz_s;

  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] divisor_r;
  logic             is_mod_r;
  logic [SHW-1:0]   cnt_r;
  logic             last_s;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;
  logic             fits_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] div_c_s;

  logic [WIDTH-1:0] c_r;
  logic             zero_r;
  logic             carry_r;
  logic             ovf_r;
  logic             dz_r;
  logic             out_valid_r;

  assign accept_s    = bus.in_valid && (state_r == IDLE);
  assign b_zero_s    = (bus.b == {WIDTH{1'b0}});
  assign div_start_s = ((bus.sel == 4'd6) || (bus.sel == 4'd7)) && !b_zero_s;
  assign last_s      = (cnt_r == SHW'(WIDTH - 1));

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.c         = c_r;
  assign bus.zero      = zero_r;
  assign bus.carry     = carry_r;
  assign bus.ovf       = ovf_r;
  assign bus.dz        = dz_r;

  // Single-cycle result and flags for the opcode currently on the inputs.
  always_comb begin
    sum_s       = {1'b0, bus.a} + {1'b0, bus.b};
    diff_s      = {1'b0, bus.a} - {1'b0, bus.b};
    alu_c_s     = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_dz_s    = 1'b0;
    case (bus.sel)
      4'd0: alu_c_s = bus.a & bus.b;
      4'd1: alu_c_s = bus.a | bus.b;
      4'd2: alu_c_s = bus.a ^ bus.b;
      4'd3: alu_c_s = ~bus.a;
      4'd4: begin
        alu_c_s     = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                      (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd5: begin
        alu_c_s     = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      // Only the divide-by-zero case finishes here; a non-zero divisor
      // goes to the iterative divider instead.
      4'd6: begin
        alu_c_s  = bus.a;
        alu_dz_s = b_zero_s;
      end
      4'd7: begin
        alu_c_s  = {WIDTH{1'b1}};
        alu_dz_s = b_zero_s;
      end
      4'd8:  alu_c_s = bus.a >> bus.b[SHW-1:0];
      4'd9:  alu_c_s = bus.a << bus.b[SHW-1:0];
      4'd10: alu_c_s = (bus.b > bus.a) ? bus.b : bus.a;
      4'd11: alu_c_s = (bus.b < bus.a) ? bus.b : bus.a;
      4'd12: alu_c_s = !bus.a[0] ? bus.a : (!bus.b[0] ? bus.b : {WIDTH{1'b0}});
      4'd13: alu_c_s = bus.a[0] ? bus.a : (bus.b[0] ? bus.b : {WIDTH{1'b0}});
      4'd14: alu_c_s = {{(WIDTH-1){1'b0}}, parity_f(bus.a)};
      4'd15: alu_c_s = {{(WIDTH-1){1'b0}}, parity_f(bus.b)};
      default: alu_c_s = {WIDTH{1'b0}};
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, try to
  // subtract the divisor, keep the difference if it did not go negative.
  always_comb begin
    shift_s    = {rem_r, quo_r[WIDTH-1]};
    trial_s    = shift_s - {1'b0, divisor_r};
    fits_s     = !trial_s[WIDTH];
    quo_next_s = {quo_r[WIDTH-2:0], fits_s};
    if (fits_s) begin
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      rem_next_s = shift_s[WIDTH-1:0];
    end
    if (is_mod_r) begin
      div_c_s = rem_next_s;
    end else begin
      div_c_s = quo_next_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = div_start_s ? BUSY : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, divider iteration and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      divisor_r   <= {WIDTH{1'b0}};
      is_mod_r    <= 1'b0;
      cnt_r       <= {SHW{1'b0}};
      c_r         <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      dz_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (div_start_s) begin
              quo_r     <= bus.a;
              rem_r     <= {WIDTH{1'b0}};
              divisor_r <= bus.b;
              is_mod_r  <= (bus.sel == 4'd6);
              cnt_r     <= {SHW{1'b0}};
            end else begin
              c_r         <= alu_c_s;
              zero_r      <= (alu_c_s == {WIDTH{1'b0}});
              carry_r     <= alu_carry_s;
              ovf_r       <= alu_ovf_s;
              dz_r        <= alu_dz_s;
              out_valid_r <= 1'b1;
            end
          end
        end
        BUSY: begin
          quo_r <= quo_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + SHW'(1);
          if (last_s) begin
            c_r         <= div_c_s;
            zero_r      <= (div_c_s == {WIDTH{1'b0}});
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule
